shift_pipe: RTL and testbench
=============================

Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter; successor to the single-cycle arithmetic right shifter.
- Supports four modes (SLL, SRL, SRA, ROR) and generic WIDTH.
- One shift-amount bit is resolved per registered stage, with a valid/ready handshake on both sides.
- Sits between the ALU operand mux and the writeback path. Results are correlated via a pass-through tag.

Parameters:
- WIDTH, 32, data width; power of 2, ≥4.
- SHAMT_W, $clog2(WIDTH), shift-amount width; also the number of pipeline stages. Derived, not to be overridden.
- TAG_W, 4, width of opaque tag carried alongside data.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block accepts request this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHAMT_W  shift amount
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
- in_tag  input  TAG_W  opaque tag
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result
- out_tag  output  TAG_W  tag of that result
- out_zero  output  1  result == 0 (only with SHIFT_ZERO_FLAG_EN)

Behaviour:
- Transfer occurs on a rising clock edge when valid && ready on the same interface.
- Pipeline stages S0..S(SHAMT_W-1):
  - Stage k registers {valid, data, shamt, op, tag}.
  - Stage k applies a shift of 2^k iff shamt[k]==1.
  - S0 takes in_*; S(SHAMT_W-1) drives out_*.
- Per-stage shift of n positions:
  - SRL: zero-fill from MSB.
  - SRA: fill with the current data MSB, which carries the original sign through the stages.
  - ROR: bits shifted out of the LSB re-enter at the MSB.
  - SLL: zero-fill from LSB.
  - SLL may be implemented as bit-reverse → SRL → bit-reverse, provided the results are identical.
- Latency: an accepted request appears on out_* exactly SHAMT_W cycles later when unstalled (5 for WIDTH=32). Throughput is 1 request per cycle.
- Back-pressure:
  - ready_k = !valid_k || ready_(k+1), with ready_SHAMT_W = out_ready; in_ready = ready_0.
  - A stage holds all of its fields while valid and not advancing.
  - The ready chain is combinational; in_ready must not depend on in_valid.
- Bubbles: a stage with valid=0 is always overwritten. Bubbles collapse under stall.
- out_data and out_tag are stable while out_valid && !out_ready.
- shamt=0 passes data unchanged in every mode.
- Ordering: results emerge strictly in acceptance order. There is no drop or duplicate.
- Reset (asynchronous, at any time including mid-operation):
  - All stage valids clear to 0 and all data/shamt/op/tag registers clear to 0.
  - In-flight requests are discarded.
  - Outputs while reset is held: out_valid=0, out_data=0, out_tag=0, out_zero=0, in_ready=1.
  - The first accept is on the first clock edge after deassertion.
- Simultaneous accept and emit in the same cycle with a full pipe is legal: every stage advances, throughput is sustained.

Optional Feature:
- Macro SHIFT_ZERO_FLAG_EN.
- Defined: port out_zero exists. The final stage registers a zero flag computed from its next data value, so out_zero is valid with out_valid, follows the same stall and hold rules, and resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package shift_pipe_pkg holds:
  - op encodings: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ROR=2'b11;
  - localparam function for the stage count.
- Sub-module shift_pipe_stage, parametrised by WIDTH, TAG_W and stage index K. It contains one register slice plus its 2^K shift/mux logic and local ready. The top instantiates SHAMT_W copies with a generate loop.

Test Plan:
- SRA, data 0x80000000, shamt 4, out_ready=1 → after 5 cycles out_data=0xF8000000; SRA 0x7FFFFFFF by 31 → 0x00000000.
- SLL 0x00000001 by 31 → 0x80000000; SRL 0x80000000 by 31 → 0x00000001; ROR 0x12345678 by 8 → 0x78123456; any op with shamt 0 → unchanged.
- Back-to-back stream:
  - Setup: 8 requests with tags 0..7, out_ready=1.
  - Unstalled: one result per cycle, tags in order, first result at cycle 5.
  - Stall: holding out_ready=0 for 10 cycles drops in_ready after 5 more accepts; out_data and out_tag are held; the stream resumes without loss.
- Bubble collapse: single request, out_ready=0 for 3 cycles after entry → result held stable and delivered once when out_ready rises.
- Reset asserted asynchronously mid-clock with 3 requests in flight → out_valid=0 immediately, nothing emitted after deassertion, next request has latency 5.
- With SHIFT_ZERO_FLAG_EN: SRL 0x0000000F by 4 → out_data=0, out_zero=1. SRL 0x000000F0 by 4 → 0x0000000F, out_zero=0.

Source files
------------

// File: rtl/shift_pipe_pkg.sv
// shift_pipe_pkg: shift op encodings and the stage-count helper shared by shift_pipe and its stages.
package shift_pipe_pkg;
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;
    function automatic int stage_count(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/shift_pipe_stage.sv
// shift_pipe_stage: one register slice of shift_pipe, shifting by 2**K when shamt[K] is set.
// With SHIFT_ZERO_FLAG_EN the LAST stage also registers a zero flag of the data it loads.
module shift_pipe_stage
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int K = 0,
`ifdef SHIFT_ZERO_FLAG_EN
    parameter bit LAST = 1'b0,
`endif
    localparam int SHAMT_W = stage_count(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [1:0]         out_op,
    output logic [TAG_W-1:0]   out_tag
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    output logic               out_zero
`endif
);
    localparam int N = 1 << K;
    logic [WIDTH-1:0] shifted, nxt;
    assign shifted = in_op == OP_SLL ? in_data << N
                   : in_op == OP_SRL ? in_data >> N
                   : in_op == OP_SRA ? {{N{in_data[WIDTH-1]}}, in_data[WIDTH-1:N]}
                   : {in_data[N-1:0], in_data[WIDTH-1:N]};
    assign nxt = in_shamt[K] ? shifted : in_data;
    // An empty slice always loads, so bubbles collapse while later stages stall.
    assign in_ready = !out_valid || out_ready;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_op    <= '0;
            out_tag   <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            out_data  <= nxt;
            out_shamt <= in_shamt;
            out_op    <= in_op;
            out_tag   <= in_tag;
        end
    end
`ifdef SHIFT_ZERO_FLAG_EN
    if (LAST) begin : g_zero
        always_ff @(posedge clock or posedge reset) begin
            if (reset) out_zero <= 1'b0;
            else if (in_ready) out_zero <= ~|nxt;
        end
    end else begin : g_no_zero
        assign out_zero = 1'b0;
    end
`endif
endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROR), one shift-amount bit per stage, valid/ready both sides.
// Optional out_zero result flag under SHIFT_ZERO_FLAG_EN.
module shift_pipe
    import shift_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int SHAMT_W = stage_count(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
`ifdef SHIFT_ZERO_FLAG_EN
    ,
    output logic               out_zero
`endif
);
    logic [SHAMT_W:0] valid, ready;
    logic [WIDTH-1:0] data [SHAMT_W+1];
    logic [SHAMT_W-1:0] shamt [SHAMT_W+1];
    logic [1:0] op [SHAMT_W+1];
    logic [TAG_W-1:0] tag [SHAMT_W+1];
    assign valid[0] = in_valid;
    assign data[0] = in_data;
    assign shamt[0] = in_shamt;
    assign op[0] = in_op;
    assign tag[0] = in_tag;
    assign in_ready = ready[0];
    assign ready[SHAMT_W] = out_ready;
    assign out_valid = valid[SHAMT_W];
    assign out_data = data[SHAMT_W];
    assign out_tag = tag[SHAMT_W];
`ifdef SHIFT_ZERO_FLAG_EN
    logic [SHAMT_W-1:0] zero;
    // Only the last stage drives a real flag; the others tie to 0.
    assign out_zero = |zero;
`endif
    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_pipe_stage #(
            .WIDTH(WIDTH),
`ifdef SHIFT_ZERO_FLAG_EN
            .LAST(k == SHAMT_W - 1),
`endif
            .TAG_W(TAG_W),
            .K(k)
        ) u_stage (
            .clock(clock),
            .reset(reset),
            .in_valid(valid[k]),
            .in_ready(ready[k]),
            .in_data(data[k]),
            .in_shamt(shamt[k]),
            .in_op(op[k]),
            .in_tag(tag[k]),
            .out_valid(valid[k+1]),
            .out_ready(ready[k+1]),
            .out_data(data[k+1]),
            .out_shamt(shamt[k+1]),
            .out_op(op[k+1]),
            .out_tag(tag[k+1])
`ifdef SHIFT_ZERO_FLAG_EN
            ,
            .out_zero(zero[k])
`endif
        );
    end
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed self-checking bench for shift_pipe (WIDTH=32, TAG_W=4).
module tb_shift_pipe;
    import shift_pipe_pkg::*;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_op = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
`ifdef SHIFT_ZERO_FLAG_EN
    logic        out_zero;
`endif
    int n_chk = 0;
    int n_pass = 0;

    shift_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clock(clock),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_shamt(in_shamt),
        .in_op(in_op),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_tag(out_tag)
`ifdef SHIFT_ZERO_FLAG_EN
        ,
        .out_zero(out_zero)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] d, input logic [4:0] sh,
                          input logic [31:0] exp, input logic [3:0] tg);
        int lat;
        @(negedge clock);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = d;
        in_shamt = sh;
        in_op = op;
        in_tag = tg;
        check("op_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("op_latency", 32'(lat), 32'd5);
        check("op_data", out_data, exp);
        check("op_tag", 32'(out_tag), 32'(tg));
`ifdef SHIFT_ZERO_FLAG_EN
        check("op_zero", 32'(out_zero), 32'(exp == 32'd0));
`endif
    endtask

    // Item i is SLL of i by 1 with tag i; out_ready is low during [stall_at, stall_at+stall_len).
    task automatic stream(input int n, input int gap, input int stall_at, input int stall_len,
                          output int first_cyc, output int last_cyc, output int stall_acc, output logic rdy_end);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        int held_bad = 0;
        int extra = 0;
        logic acc;
        logic hv = 1'b0;
        logic [31:0] hd = '0;
        logic [3:0] ht = '0;
        first_cyc = -1;
        last_cyc = -1;
        stall_acc = 0;
        rdy_end = 1'b1;
        while (got < n && cyc < 200) begin
            @(negedge clock);
            out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            in_valid = sent < n && cyc != gap;
            in_data = 32'(sent);
            in_shamt = 5'd1;
            in_op = OP_SLL;
            in_tag = 4'(sent);
            #1;
            if (out_valid && out_ready) begin
                check("stream_tag", 32'(out_tag), 32'(got[3:0]));
                check("stream_data", out_data, 32'(got * 2));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                got++;
            end
            if (out_valid && !out_ready) begin
                if (hv && (out_data !== hd || out_tag !== ht)) held_bad++;
                hv = 1'b1;
                hd = out_data;
                ht = out_tag;
            end
            acc = in_valid && in_ready;
            if (acc && !out_ready) stall_acc++;
            if (stall_len > 0 && cyc == stall_at + stall_len - 1) rdy_end = in_ready;
            @(posedge clock);
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (out_valid) extra++;
        end
        check("stream_count", 32'(got), 32'(n));
        check("stream_hold", 32'(held_bad), 32'd0);
        check("stream_no_extra", 32'(extra), 32'd0);
    endtask

    initial begin
        int f, l, sa, bad;
        logic re;
        #7;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        #5 reset = 1'b0;

        run_op(OP_SRA, 32'h8000_0000, 5'd4, 32'hF800_0000, 4'd1);
        run_op(OP_SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 4'd2);
        run_op(OP_SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 4'd3);
        run_op(OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 4'd4);
        run_op(OP_SLL, 32'h0000_F00F, 5'd5, 32'h001E_01E0, 4'd5);
        run_op(OP_SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 4'd6);
        run_op(OP_SRL, 32'hF000_0000, 5'd17, 32'h0000_7800, 4'd7);
        run_op(OP_ROR, 32'h1234_5678, 5'd8, 32'h7812_3456, 4'd8);
        run_op(OP_ROR, 32'h0000_0001, 5'd1, 32'h8000_0000, 4'd9);
        run_op(OP_SLL, 32'hA5A5_F00F, 5'd0, 32'hA5A5_F00F, 4'd10);
        run_op(OP_SRL, 32'hA5A5_F00F, 5'd0, 32'hA5A5_F00F, 4'd11);
        run_op(OP_SRA, 32'hA5A5_F00F, 5'd0, 32'hA5A5_F00F, 4'd12);
        run_op(OP_ROR, 32'hA5A5_F00F, 5'd0, 32'hA5A5_F00F, 4'd13);
        run_op(OP_SRL, 32'h0000_000F, 5'd4, 32'h0000_0000, 4'd14);
        run_op(OP_SRL, 32'h0000_00F0, 5'd4, 32'h0000_000F, 4'd15);

        stream(8, -1, 0, 0, f, l, sa, re);
        check("burst_first_cycle", 32'(f), 32'd5);
        check("burst_span", 32'(l - f), 32'd7);

        stream(12, -1, 0, 10, f, l, sa, re);
        check("stall_accepts", 32'(sa), 32'd5);
        check("stall_in_ready", 32'(re), 32'd0);
        check("stall_first_cycle", 32'(f), 32'd10);
        check("stall_span", 32'(l - f), 32'd11);

        stream(2, 1, 0, 7, f, l, sa, re);
        check("bubble_accepts", 32'(sa), 32'd2);
        check("bubble_first_cycle", 32'(f), 32'd7);
        check("bubble_second_cycle", 32'(l), 32'd8);

        @(negedge clock);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data = 32'h100 + 32'(i);
            in_shamt = 5'd0;
            in_op = OP_SRL;
            in_tag = 4'(i + 1);
            @(negedge clock);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        check("pre_reset_data", out_data, 32'h100);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", out_data, 32'd0);
        check("async_rst_tag", 32'(out_tag), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SHIFT_ZERO_FLAG_EN
        check("async_rst_zero", 32'(out_zero), 32'd0);
`endif
        @(negedge clock);
        #2 reset = 1'b0;
        out_ready = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clock);
            if (out_valid) bad++;
        end
        check("post_reset_quiet", 32'(bad), 32'd0);
        run_op(OP_ROR, 32'hDEAD_BEEF, 5'd16, 32'hBEEF_DEAD, 4'd6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
